snake_seg_arbiter: RTL and testbench
====================================

# snake_seg_arbiter

Owns the snake segment store: a circular buffer of body coordinates held in a single-port synchronous RAM. It arbitrates that RAM between three requesters: the VGA renderer's per-frame body walk, the game engine's move/grow/init updates, and the collision scanner. It sits between the game FSM and the VGA renderer, and supplies the renderer's `q_addr`/`q_x`/`q_y`/`q_vld` query port.

## Interface
- `X_BITS`, 6: x coordinate width
- `Y_BITS`, 6: y coordinate width
- `S_ADDR_W`, 8: segment index width; buffer depth is 2^S_ADDR_W
- `S_LEN_W`, 9: length width; must hold 2^S_ADDR_W
- `clk` in 1: system clock
- `rst_n` in 1: asynchronous, active-low reset
- `init_req` in 1: level; resets the snake to length 1 with head at (`mv_x`, `mv_y`)
- `mv_req` in 1: level, held until `mv_ack`; pushes a new head
- `mv_grow` in 1: sampled with `mv_req`; if 1, keep the tail
- `mv_x` in X_BITS, `mv_y` in Y_BITS: new head (or init) coordinate
- `mv_ack` out 1: one-cycle pulse when an init or move is applied
- `hit_req` in 1: level, held until `hit_done`; scan the body for (`hit_x`, `hit_y`)
- `hit_x` in X_BITS, `hit_y` in Y_BITS: probe coordinate
- `hit_done` out 1: one-cycle pulse ending a scan
- `hit` out 1: valid with `hit_done`; 1 if any segment index 1..len-1 matches the probe
- `r_act` in 1: renderer body walk active
- `q_addr` in S_ADDR_W: logical index; 0 is the head
- `q_x` out X_BITS, `q_y` out Y_BITS, `q_vld` out 1: query result
- `len` out S_LEN_W: current length
- `hx` out X_BITS, `hy` out Y_BITS: head coordinate (registered copy)

## Operation
- Storage is a ring. Head pointer `hp` holds the physical address of logical index 0.
- Logical index i maps to physical address (hp − i) mod 2^S_ADDR_W.
- Port priority per cycle: renderer (`r_act`=1), then init, then move, then scan read. Only one RAM access happens per cycle.
- Renderer:
  - While `r_act`=1, read physical address (hp − q_addr) every cycle.
  - `q_vld`=1 only if `q_addr` < `len`.
  - While `r_act`=1, no write occurs, so the ring is frozen during the walk.
- Init:
  - Write (`mv_x`, `mv_y`) at hp+1.
  - hp += 1, `len` := 1, `hx`/`hy` := (`mv_x`, `mv_y`), pulse `mv_ack`.
  - Init has priority over move when both are asserted.
- Move:
  - Write at hp+1, hp += 1, update `hx`/`hy`.
  - If `mv_grow`=1 and `len` < 2^S_ADDR_W, then `len` += 1.
  - Growth saturates at the maximum length; the oldest segment is then overwritten.
  - Move with `len`=0 behaves as init.
- FSM states:
  - IDLE to SCAN on `hit_req` when `len` ≥ 2; index i := 1.
  - IDLE to DONE on `hit_req` when `len` ≤ 1, with `hit`=0.
  - SCAN issues a read of index i on each cycle it wins the RAM. Compare happens the following cycle.
  - On a match, or after comparing i = len−1, go to DONE.
  - DONE pulses `hit_done` for one cycle, then returns to IDLE.
- Init and move are accepted only in IDLE. While in SCAN or DONE they are held off, which keeps the scan consistent.
- If `hit_req` and `mv_req` are both pending in IDLE, the move is applied first. The scan starts the next cycle.

## Timing
- Reset values:
  - `len`=0, hp=0, `hx`=`hy`=0
  - `q_x`=`q_y`=0, `q_vld`=0
  - `mv_ack`=0, `hit_done`=0, `hit`=0
  - FSM in IDLE
- Query latency is 1 cycle: `q_addr` sampled at edge N gives `q_x`/`q_y`/`q_vld` registered at edge N+1. When `r_act`=0, `q_vld`=0.
- Move/init: accepted at edge N; `mv_ack`, `len`, `hx`, `hy` and hp are all updated at edge N+1.
- Scan with the bus uncontended:
  - A miss on length L asserts `hit_done` L+1 cycles after acceptance.
  - A match at index k asserts it after k+2 cycles.
  - Each cycle with `r_act`=1 stalls the scan by one cycle.
- Reset mid-scan aborts the scan with no `hit_done` pulse.
- Deasserting `hit_req` mid-scan does not abort; the scan still completes.

## Structure
- Shared package `snake_pkg`: default widths X_BITS, Y_BITS, S_ADDR_W, S_LEN_W, and the FSM state encodings (IDLE, SCAN, DONE).
- Sub-module `snake_seg_ram`: single-port RAM, 2^S_ADDR_W × (X_BITS+Y_BITS), synchronous read and write, no reset.

## Test plan
- Reset, then init at (10,5) -> `mv_ack` pulse; `len`=1; `hx`,`hy`=10,5; `q_addr`=0 with `r_act` gives (10,5) and `q_vld`=1 one cycle later.
- Init (10,5), then grow-moves to (11,5) and (12,5), then a plain move to (13,5) -> `len`=3; `q_addr` 0,1,2 return (13,5),(12,5),(11,5); `q_addr`=3 gives `q_vld`=0.
- 300 grow-moves with S_ADDR_W=8 -> `len` saturates at 256; the ring wraps and `q_addr`=255 returns the 256th-newest head.
- Body (13,5),(12,5),(11,5): scan (11,5) -> `hit`=1; scan (13,5) -> `hit`=0, since the head is excluded; scan with `len`=1 -> `hit_done` next cycle, `hit`=0.
- Scan while `r_act` is toggled every other cycle, with `mv_req` asserted mid-scan -> scan result correct and latency extended by the stall count; `mv_ack` only after `hit_done`.
- Assert `rst_n`=0 during SCAN -> all outputs return to reset values and no `hit_done` is emitted.

Source files
------------

// File: rtl/snake_pkg.sv
// snake_pkg: shared widths and scan FSM encoding for the snake segment store
package snake_pkg;
   localparam int SNAKE_X_BITS = 6;
   localparam int SNAKE_Y_BITS = 6;
   localparam int SNAKE_ADDR_W = 8;
   localparam int SNAKE_LEN_W  = 9;
   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
endpackage

// File: rtl/snake_seg_arbiter_if.sv
// snake_seg_arbiter_if: requester-side bundle of the segment store (engine, scanner, renderer)
interface snake_seg_arbiter_if
   import snake_pkg::*;
#(
   parameter int X_BITS   = SNAKE_X_BITS,
   parameter int Y_BITS   = SNAKE_Y_BITS,
   parameter int S_ADDR_W = SNAKE_ADDR_W,
   parameter int S_LEN_W  = SNAKE_LEN_W
) ();
   logic                init_req;
   logic                mv_req;
   logic                mv_grow;
   logic [X_BITS-1:0]   mv_x;
   logic [Y_BITS-1:0]   mv_y;
   logic                mv_ack;
   logic                hit_req;
   logic [X_BITS-1:0]   hit_x;
   logic [Y_BITS-1:0]   hit_y;
   logic                hit_done;
   logic                hit;
   logic                r_act;
   logic [S_ADDR_W-1:0] q_addr;
   logic [X_BITS-1:0]   q_x;
   logic [Y_BITS-1:0]   q_y;
   logic                q_vld;
   logic [S_LEN_W-1:0]  len;
   logic [X_BITS-1:0]   hx;
   logic [Y_BITS-1:0]   hy;
   modport master (
      output init_req, mv_req, mv_grow, mv_x, mv_y, hit_req, hit_x, hit_y, r_act, q_addr,
      input  mv_ack, hit_done, hit, q_x, q_y, q_vld, len, hx, hy
   );
   modport slave (
      input  init_req, mv_req, mv_grow, mv_x, mv_y, hit_req, hit_x, hit_y, r_act, q_addr,
      output mv_ack, hit_done, hit, q_x, q_y, q_vld, len, hx, hy
   );
endinterface

// File: rtl/snake_seg_ram.sv
// snake_seg_ram: single-port segment RAM, synchronous read and write, no reset
module snake_seg_ram
   import snake_pkg::*;
#(
   parameter int AW = SNAKE_ADDR_W,
   parameter int DW = SNAKE_X_BITS + SNAKE_Y_BITS
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] addr,
   input  logic [DW-1:0] wdata,
   output logic [DW-1:0] rdata
);
   logic [DW-1:0] mem [2**AW];
   // one access per cycle: optional write plus registered read of the same address
   always_ff @(posedge clk) begin
      if (we) mem[addr] <= wdata;
      rdata <= mem[addr];
   end
endmodule

// File: rtl/snake_seg_arbiter.sv
// snake_seg_arbiter: ring-buffer segment store arbitrated between renderer, engine and collision scan
module snake_seg_arbiter
   import snake_pkg::*;
#(
   parameter int X_BITS   = SNAKE_X_BITS,
   parameter int Y_BITS   = SNAKE_Y_BITS,
   parameter int S_ADDR_W = SNAKE_ADDR_W,
   parameter int S_LEN_W  = SNAKE_LEN_W
) (
   input logic               clk,
   input logic               rst_n,
   snake_seg_arbiter_if.slave bus
);
   localparam int DW = X_BITS + Y_BITS;
   localparam logic [S_LEN_W-1:0] DEPTH = S_LEN_W'(2**S_ADDR_W);

   state_t              state, state_nx;
   logic [S_ADDR_W-1:0] hp, addr;
   logic [S_LEN_W-1:0]  len, rd_i;
   logic [X_BITS-1:0]   hx;
   logic [Y_BITS-1:0]   hy;
   logic [DW-1:0]       rdata, sd, cmp_data;
   logic                mv_ack, hit_done, hit, q_vld, found;
   logic                pend, wr_go, scan_go, adv, scan_rd, fresh, cmp_vld, cmp_last, match;

   snake_seg_ram #(.AW(S_ADDR_W), .DW(DW)) u_ram (
      .clk   (clk),
      .we    (wr_go),
      .addr  (addr),
      .wdata ({bus.mv_x, bus.mv_y}),
      .rdata (rdata)
   );

   // port arbitration: renderer, then init/move, then scan; the cycle after an ack blocks a re-apply of the held request
   always_comb begin
      pend     = (bus.init_req || bus.mv_req) && !mv_ack;
      wr_go    = state == IDLE && !bus.r_act && pend;
      scan_go  = state == IDLE && bus.hit_req && !hit_done && !pend;
      adv      = !bus.r_act;
      scan_rd  = state == SCAN && adv && rd_i < len;
      addr     = bus.r_act ? hp - bus.q_addr :
                 wr_go     ? hp + S_ADDR_W'(1) : hp - rd_i[S_ADDR_W-1:0];
      cmp_data = fresh ? rdata : sd;
      match    = cmp_data == {bus.hit_x, bus.hit_y};
   end

   // scan FSM next state; a renderer cycle freezes the scan including its pending compare
   always_comb begin
      state_nx = state;
      if (state == IDLE && scan_go) state_nx = len >= S_LEN_W'(2) ? SCAN : DONE;
      else if (state == SCAN && adv && cmp_vld && (match || cmp_last)) state_nx = DONE;
      else if (state == DONE) state_nx = IDLE;
   end

   // scan FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else state <= state_nx;
   end

   // ring pointer, length, head copy, query valid and scan pipeline
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hp       <= '0;
         len      <= '0;
         hx       <= '0;
         hy       <= '0;
         mv_ack   <= 1'b0;
         q_vld    <= 1'b0;
         hit_done <= 1'b0;
         hit      <= 1'b0;
         found    <= 1'b0;
         rd_i     <= '0;
         cmp_vld  <= 1'b0;
         cmp_last <= 1'b0;
         fresh    <= 1'b0;
         sd       <= '0;
      end else begin
         mv_ack   <= wr_go;
         q_vld    <= bus.r_act && S_LEN_W'(bus.q_addr) < len;
         hit_done <= state == DONE;
         fresh    <= scan_rd;
         if (fresh) sd <= rdata;
         if (state == DONE) hit <= found;
         if (wr_go) begin
            hp  <= hp + S_ADDR_W'(1);
            hx  <= bus.mv_x;
            hy  <= bus.mv_y;
            len <= (bus.init_req || len == '0) ? S_LEN_W'(1) :
                   (bus.mv_grow && len < DEPTH) ? len + S_LEN_W'(1) : len;
         end
         if (scan_go) begin
            rd_i  <= S_LEN_W'(1);
            found <= 1'b0;
         end else if (scan_rd) rd_i <= rd_i + S_LEN_W'(1);
         if (state != SCAN) begin
            cmp_vld  <= 1'b0;
            cmp_last <= 1'b0;
         end else if (adv) begin
            cmp_vld  <= scan_rd;
            cmp_last <= rd_i + S_LEN_W'(1) == len;
            if (cmp_vld && match) found <= 1'b1;
         end
      end
   end

   assign bus.mv_ack   = mv_ack;
   assign bus.hit_done = hit_done;
   assign bus.hit      = hit;
   assign bus.q_vld    = q_vld;
   assign bus.q_x      = q_vld ? rdata[DW-1:Y_BITS] : '0;
   assign bus.q_y      = q_vld ? rdata[Y_BITS-1:0] : '0;
   assign bus.len      = len;
   assign bus.hx       = hx;
   assign bus.hy       = hy;
endmodule

// File: tb/tb_snake_seg_arbiter.sv
// tb_snake_seg_arbiter: vector table, hand sequences and random ops against a queue model of the body
module tb_snake_seg_arbiter;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   snake_seg_arbiter_if bus ();
   snake_seg_arbiter dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   int checks = 0;
   int errors = 0;
   logic [11:0] body [$];

   typedef struct {
      int op;
      int x;
      int y;
      int a;
      int e_len;
      int e_vld;
      int e_x;
      int e_y;
      int e_hit;
      int e_lat;
   } vec_t;
   vec_t tv [14];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic void m_init(input int x, input int y);
      body.delete();
      body.push_front({6'(x), 6'(y)});
   endfunction

   function automatic void m_move(input int x, input int y, input bit g);
      if (body.size() == 0) m_init(x, y);
      else begin
         body.push_front({6'(x), 6'(y)});
         if (!g || body.size() > 256) void'(body.pop_back());
      end
   endfunction

   function automatic void m_scan(input int x, input int y, output int hit, output int lat);
      int l;
      l = body.size();
      hit = 0;
      lat = l <= 1 ? 1 : l + 1;
      for (int k = 1; k < l; k++)
         if (body[k] == {6'(x), 6'(y)}) begin
            hit = 1;
            lat = k + 2;
            break;
         end
   endfunction

   task automatic do_wr(input bit ini, input int x, input int y, input bit g);
      int n;
      n = 0;
      bus.mv_x = 6'(x);
      bus.mv_y = 6'(y);
      bus.mv_grow = g;
      bus.init_req = ini;
      bus.mv_req = !ini;
      while (!bus.mv_ack && n < 20) begin
         tick;
         n++;
      end
      bus.init_req = 1'b0;
      bus.mv_req = 1'b0;
      chk("mv_ack_seen", int'(bus.mv_ack), 1);
      if (ini) m_init(x, y);
      else m_move(x, y, g);
      chk("len", int'(bus.len), body.size());
      chk("hx", int'(bus.hx), x);
      chk("hy", int'(bus.hy), y);
      tick;
      chk("mv_ack_pulse", int'(bus.mv_ack), 0);
   endtask

   task automatic do_query(input int a, output int vld, output int x, output int y);
      bus.r_act = 1'b1;
      bus.q_addr = 8'(a);
      tick;
      vld = int'(bus.q_vld);
      x = int'(bus.q_x);
      y = int'(bus.q_y);
      bus.r_act = 1'b0;
   endtask

   task automatic chk_q(input int a);
      int v, x, y;
      do_query(a, v, x, y);
      chk("q_vld", v, int'(a < body.size()));
      if (a < body.size()) begin
         chk("q_x", x, int'(body[a][11:6]));
         chk("q_y", y, int'(body[a][5:0]));
      end
   endtask

   task automatic do_scan(input int x, input int y, output int hit, output int lat);
      int n;
      n = 0;
      bus.hit_x = 6'(x);
      bus.hit_y = 6'(y);
      bus.hit_req = 1'b1;
      while (!bus.hit_done && n < 1000) begin
         tick;
         n++;
      end
      bus.hit_req = 1'b0;
      hit = int'(bus.hit);
      lat = bus.hit_done ? n - 1 : -1;
      tick;
      chk("hit_done_pulse", int'(bus.hit_done), 0);
   endtask

   task automatic chk_reset_outputs;
      chk("rst_len", int'(bus.len), 0);
      chk("rst_hx", int'(bus.hx), 0);
      chk("rst_hy", int'(bus.hy), 0);
      chk("rst_q_x", int'(bus.q_x), 0);
      chk("rst_q_y", int'(bus.q_y), 0);
      chk("rst_q_vld", int'(bus.q_vld), 0);
      chk("rst_mv_ack", int'(bus.mv_ack), 0);
      chk("rst_hit_done", int'(bus.hit_done), 0);
      chk("rst_hit", int'(bus.hit), 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      int v, x, y, h, l, eh, el, r, a, p, cp, c, done_c, hit_act, early, n, seen;
      tv = '{
         '{0, 10, 5, 0, 1, 0, 0, 0, 0, 0},
         '{3,  0, 0, 0, 0, 1, 10, 5, 0, 0},
         '{1, 11, 5, 0, 2, 0, 0, 0, 0, 0},
         '{1, 12, 5, 0, 3, 0, 0, 0, 0, 0},
         '{2, 13, 5, 0, 3, 0, 0, 0, 0, 0},
         '{3,  0, 0, 0, 0, 1, 13, 5, 0, 0},
         '{3,  0, 0, 1, 0, 1, 12, 5, 0, 0},
         '{3,  0, 0, 2, 0, 1, 11, 5, 0, 0},
         '{3,  0, 0, 3, 0, 0, 0, 0, 0, 0},
         '{4, 11, 5, 0, 0, 0, 0, 0, 1, 4},
         '{4, 13, 5, 0, 0, 0, 0, 0, 0, 4},
         '{4, 12, 5, 0, 0, 0, 0, 0, 1, 3},
         '{0,  7, 7, 0, 1, 0, 0, 0, 0, 0},
         '{4,  7, 7, 0, 0, 0, 0, 0, 0, 1}
      };
      bus.init_req = 1'b0;
      bus.mv_req = 1'b0;
      bus.mv_grow = 1'b0;
      bus.mv_x = '0;
      bus.mv_y = '0;
      bus.hit_req = 1'b0;
      bus.hit_x = '0;
      bus.hit_y = '0;
      bus.r_act = 1'b0;
      bus.q_addr = '0;
      tick;
      tick;
      chk_reset_outputs();
      rst_n = 1'b1;
      tick;

      for (int i = 0; i < 14; i++) begin
         if (tv[i].op <= 2) begin
            do_wr(tv[i].op == 0, tv[i].x, tv[i].y, tv[i].op == 1);
            chk("tv_len", int'(bus.len), tv[i].e_len);
         end else if (tv[i].op == 3) begin
            do_query(tv[i].a, v, x, y);
            chk("tv_q_vld", v, tv[i].e_vld);
            if (tv[i].e_vld != 0) begin
               chk("tv_q_x", x, tv[i].e_x);
               chk("tv_q_y", y, tv[i].e_y);
            end
         end else begin
            do_scan(tv[i].x, tv[i].y, h, l);
            chk("tv_hit", h, tv[i].e_hit);
            chk("tv_lat", l, tv[i].e_lat);
         end
      end

      do_wr(1, 0, 0, 0);
      for (int j = 1; j <= 300; j++) do_wr(0, j % 64, j / 64, 1);
      chk("sat_len", int'(bus.len), 256);
      do_query(255, v, x, y);
      chk("sat_q255_vld", v, 1);
      chk("sat_q255_x", x, 45);
      chk("sat_q255_y", y, 0);
      chk_q(0);
      chk_q(128);
      chk_q(255);
      m_scan(45, 0, eh, el);
      do_scan(45, 0, h, l);
      chk("sat_hit", h, eh);
      chk("sat_lat", l, el);
      m_scan(63, 63, eh, el);
      do_scan(63, 63, h, l);
      chk("sat_miss_hit", h, eh);
      chk("sat_miss_lat", l, el);

      do_wr(1, 3, 3, 0);
      for (int it = 0; it < 80; it++) begin
         r = $urandom_range(0, 9);
         x = $urandom_range(0, 7);
         y = $urandom_range(0, 7);
         if (r == 0) do_wr(1, x, y, 0);
         else if (r < 5) do_wr(0, x, y, bit'($urandom_range(0, 1)));
         else if (r < 7) begin
            a = $urandom_range(0, body.size() + 2);
            chk_q(a > 255 ? 255 : a);
         end else begin
            m_scan(x, y, eh, el);
            do_scan(x, y, h, l);
            chk("rnd_hit", h, eh);
            chk("rnd_lat", l, el);
         end
      end

      do_wr(1, 20, 20, 0);
      for (int i = 21; i <= 24; i++) do_wr(0, i, 20, 1);
      m_scan(20, 20, eh, el);
      p = 0;
      cp = 0;
      while (p < el - 1) begin
         cp++;
         if (cp % 2 == 0) p++;
      end
      bus.hit_x = 6'd20;
      bus.hit_y = 6'd20;
      bus.hit_req = 1'b1;
      bus.q_addr = '0;
      tick;
      done_c = -1;
      hit_act = -1;
      early = 0;
      c = 0;
      while (done_c < 0 && c < 300) begin
         c++;
         bus.r_act = c % 2 == 1;
         if (c == 3) begin
            bus.mv_x = 6'd30;
            bus.mv_y = 6'd30;
            bus.mv_grow = 1'b1;
            bus.mv_req = 1'b1;
         end
         tick;
         if (bus.mv_ack) early = 1;
         if (bus.hit_done) begin
            done_c = c;
            hit_act = int'(bus.hit);
         end
      end
      bus.r_act = 1'b0;
      bus.hit_req = 1'b0;
      chk("stall_done_cycle", done_c, cp + 1);
      chk("stall_hit", hit_act, eh);
      chk("stall_ack_before_done", early, 0);
      n = 0;
      while (!bus.mv_ack && n < 20) begin
         tick;
         n++;
      end
      chk("stall_mv_ack", int'(bus.mv_ack), 1);
      bus.mv_req = 1'b0;
      m_move(30, 30, 1);
      chk("stall_len", int'(bus.len), body.size());
      tick;
      chk_q(0);
      chk_q(5);

      bus.hit_x = 6'd63;
      bus.hit_y = 6'd63;
      bus.hit_req = 1'b1;
      tick;
      tick;
      tick;
      #2;
      rst_n = 1'b0;
      bus.hit_req = 1'b0;
      #1;
      chk_reset_outputs();
      tick;
      tick;
      rst_n = 1'b1;
      body.delete();
      seen = 0;
      for (int i = 0; i < 20; i++) begin
         tick;
         if (bus.hit_done) seen = 1;
      end
      chk("rst_no_hit_done", seen, 0);
      chk("rst_len_after", int'(bus.len), 0);
      chk_q(0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
